// File: rtl/ecc_op_dispatcher_if.sv
// Request/command bundle between the ECC operation producer and the dispatcher.
interface ecc_op_dispatcher_if #(
    parameter int unsigned LEN_W = 10
);
    logic             req_valid;
    logic             req_ready;
    logic             req_kind;
    logic [LEN_W-1:0] req_len;
    logic [5:0]       command;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       cur_chunks;

    modport master (
        output req_valid, req_kind, req_len,
        input  req_ready, command, busy, done, err, cur_chunks
    );

    modport slave (
        input  req_valid, req_kind, req_len,
        output req_ready, command, busy, done, err, cur_chunks
    );
endinterface

// File: rtl/ecc_op_dispatcher.sv
// Buffers ECC operation requests, maps each to an opcode ROM selector,
// strobes the ROM and waits out the opcode burst before reporting done/err.
module ecc_op_dispatcher #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned ROM_LAT    = 2,
    parameter int unsigned LEN_W      = 10
) (
    input logic                clk,
    input logic                rst_n,
    ecc_op_dispatcher_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WCNT_W = $clog2(5 + ROM_LAT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    typedef struct packed {
        logic             kind;
        logic [LEN_W-1:0] len;
    } req_t;

    logic [2:0]        state_q, state_d;
    req_t              fifo_q [FIFO_DEPTH];
    req_t              fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [4:0]        code_q, code_d;
    logic [2:0]        n_q, n_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    logic [5:0]        command_q, command_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [2:0]        chunks_q, chunks_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    req_t              head;
    logic [31:0]       head_len;
    logic              dec_ok;
    logic [4:0]        dec_code;
    logic [2:0]        dec_n;
    logic              push;
    logic              pop;

    assign head = fifo_q[rd_ptr_q];

    // Length/kind to ROM selector and chunk count for the FIFO head.
    always_comb begin
        dec_ok   = 1'b0;
        dec_code = 5'd0;
        dec_n    = 3'd0;
        head_len = 32'(head.len);
        if (head_len != 32'd0) begin
            if (!head.kind) begin
                if (head_len <= 32'd128) begin
                    dec_ok = 1'b1; dec_code = 5'd1; dec_n = 3'd1;
                end else if (head_len <= 32'd256) begin
                    dec_ok = 1'b1; dec_code = 5'd2; dec_n = 3'd2;
                end else if (head_len <= 32'd384) begin
                    dec_ok = 1'b1; dec_code = 5'd3; dec_n = 3'd3;
                end else if (head_len <= 32'd512) begin
                    dec_ok = 1'b1; dec_code = 5'd4; dec_n = 3'd4;
                end else if (head_len <= 32'd576) begin
                    dec_ok = 1'b1; dec_code = 5'd5; dec_n = 3'd5;
                end
            end else begin
                if (head_len <= 32'd128) begin
                    dec_ok = 1'b1; dec_code = 5'd6; dec_n = 3'd1;
                end else if (head_len <= 32'd256) begin
                    dec_ok = 1'b1; dec_code = 5'd7; dec_n = 3'd2;
                end else if (head_len <= 32'd384) begin
                    dec_ok = 1'b1; dec_code = 5'd8; dec_n = 3'd3;
                end
            end
        end
    end

    // Next state, FIFO bookkeeping and registered output values.
    always_comb begin
        state_d  = state_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        code_d   = code_q;
        n_d      = n_q;
        wcnt_d   = wcnt_q;
        push     = bus.req_valid && ready_q;
        pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pop     = 1'b1;
                code_d  = dec_code;
                n_d     = dec_n;
                state_d = dec_ok ? S_ISSUE : S_ERR;
            end
            S_ISSUE: begin
                wcnt_d  = WCNT_W'(32'(n_q) + ROM_LAT - 32'd1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            S_DONE: begin
                n_d     = 3'd0;
                code_d  = 5'd0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                n_d     = 3'd0;
                code_d  = 5'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push) begin
            fifo_d[wr_ptr_q] = '{kind: bus.req_kind, len: bus.req_len};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        command_d = 6'h00;
        if (state_d == S_ISSUE) begin
            command_d = {1'b1, code_d};
        end else if (state_d == S_WAIT) begin
            command_d = {1'b0, code_d};
        end
        chunks_d = (state_d == S_ISSUE || state_d == S_WAIT || state_d == S_DONE) ? n_d : 3'd0;
        done_d   = (state_d == S_DONE);
        err_d    = (state_d == S_ERR);
        ready_d  = (count_d != CNT_W'(FIFO_DEPTH));
        busy_d   = (state_d != S_IDLE) || (count_d != '0);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO, operation context and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            code_q    <= '0;
            n_q       <= '0;
            wcnt_q    <= '0;
            command_q <= 6'h00;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            chunks_q  <= 3'd0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            code_q    <= code_d;
            n_q       <= n_d;
            wcnt_q    <= wcnt_d;
            command_q <= command_d;
            done_q    <= done_d;
            err_q     <= err_d;
            chunks_q  <= chunks_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.command    = command_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.cur_chunks = chunks_q;
    assign bus.req_ready  = ready_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ecc_op_dispatcher.sv
// Directed bench for ecc_op_dispatcher: decode table, queued sequences, reset mid-operation.
module tb_ecc_op_dispatcher;
    localparam int ROM_LAT = 2;

    typedef struct {
        logic       kind;
        logic [9:0] len;
        logic       ok;
        logic [4:0] code;
        logic [2:0] n;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    vec_t vecs [18];

    int sq_kind [6];
    int sq_len  [6];
    int sq_code [6];
    int sq_n    [6];
    int sq_gap  [6];

    int ev_type [16];
    int ev_cyc  [16];
    int ev_code [16];
    int ev_cnt;

    ecc_op_dispatcher_if #(.LEN_W(10)) bus ();

    ecc_op_dispatcher #(
        .FIFO_DEPTH(2),
        .ROM_LAT   (ROM_LAT),
        .LEN_W     (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int outv();
        return int'({bus.busy, bus.command, bus.done, bus.err, bus.cur_chunks});
    endfunction

    // One request from idle, checked cycle by cycle against the expected trace.
    task automatic run_vec(input int idx, input vec_t v);
        int          nr;
        int          last;
        logic        e_busy;
        logic [5:0]  e_cmd;
        logic        e_done;
        logic        e_err;
        logic [2:0]  e_ch;
        nr   = int'(v.n) + ROM_LAT;
        last = v.ok ? 4 + nr : 3;
        @(negedge clk);
        chk($sformatf("vec%0d_ready", idx), int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_kind  = v.kind;
        bus.req_len   = v.len;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            e_busy = 1'b0; e_cmd = 6'h00; e_done = 1'b0; e_err = 1'b0; e_ch = 3'd0;
            if (v.ok) begin
                e_busy = (k <= 3 + nr);
                if (k == 2) begin
                    e_cmd = {1'b1, v.code}; e_ch = v.n;
                end else if (k >= 3 && k <= 2 + nr) begin
                    e_cmd = {1'b0, v.code}; e_ch = v.n;
                end else if (k == 3 + nr) begin
                    e_done = 1'b1; e_ch = v.n;
                end
            end else begin
                e_busy = (k <= 2);
                e_err  = (k == 2);
            end
            chk($sformatf("vec%0d_k%0d", idx, k), outv(),
                int'({e_busy, e_cmd, e_done, e_err, e_ch}));
        end
    endtask

    task automatic drive(input int nops, input bit chk_full);
        int w;
        for (int i = 0; i < nops; i++) begin
            repeat (sq_gap[i]) @(negedge clk);
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_kind  = sq_kind[i][0];
            bus.req_len   = sq_len[i][9:0];
            if (sq_gap[i] != 0) begin
                chk($sformatf("ready_while_busy%0d", i),
                    int'({bus.busy, bus.req_ready}), 3);
            end
            w = 0;
            while (!bus.req_ready && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) chk($sformatf("accept_timeout%0d", i), w, 0);
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            if (chk_full && i == 1) begin
                @(negedge clk);
                chk("ready_full", int'(bus.req_ready), 0);
            end
        end
    endtask

    task automatic monitor(input int nops);
        int cyc;
        int ends;
        cyc  = 0;
        ends = 0;
        while (ends < nops && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (bus.command[5] && ev_cnt < 16) begin
                ev_type[ev_cnt] = 1; ev_cyc[ev_cnt] = cyc; ev_code[ev_cnt] = int'(bus.command[4:0]);
                ev_cnt++;
            end
            if (bus.done && ev_cnt < 16) begin
                ev_type[ev_cnt] = 2; ev_cyc[ev_cnt] = cyc; ev_code[ev_cnt] = 0;
                ev_cnt++;
            end
            if (bus.err && ev_cnt < 16) begin
                ev_type[ev_cnt] = 3; ev_cyc[ev_cnt] = cyc; ev_code[ev_cnt] = 0;
                ev_cnt++;
            end
            if (bus.done || bus.err) ends++;
        end
        chk("seq_ends", ends, nops);
    endtask

    // Queued requests: order, selectors, done latency and the IDLE gap between ops.
    task automatic run_seq(input string nm, input int nops, input bit chk_full);
        int j;
        int prev_end;
        int exp_ev;
        for (int i = 0; i < 16; i++) begin
            ev_type[i] = 0; ev_cyc[i] = 0; ev_code[i] = 0;
        end
        ev_cnt = 0;
        fork
            drive(nops, chk_full);
            monitor(nops);
        join
        j        = 0;
        prev_end = 0;
        exp_ev   = 0;
        for (int i = 0; i < nops; i++) begin
            if (sq_code[i] != 0) begin
                chk($sformatf("%s_op%0d_strobe", nm, i), ev_type[j], 1);
                chk($sformatf("%s_op%0d_code", nm, i), ev_code[j], sq_code[i]);
                chk($sformatf("%s_op%0d_done", nm, i), ev_type[j+1], 2);
                chk($sformatf("%s_op%0d_lat", nm, i), ev_cyc[j+1] - ev_cyc[j], sq_n[i] + ROM_LAT + 1);
                if (i > 0) chk($sformatf("%s_op%0d_gap", nm, i), ev_cyc[j] - prev_end, 3);
                prev_end = ev_cyc[j+1];
                j += 2;
                exp_ev += 2;
            end else begin
                chk($sformatf("%s_op%0d_err", nm, i), ev_type[j], 3);
                if (i > 0) chk($sformatf("%s_op%0d_gap", nm, i), ev_cyc[j] - prev_end, 3);
                prev_end = ev_cyc[j];
                j += 1;
                exp_ev += 1;
            end
        end
        chk($sformatf("%s_events", nm), ev_cnt, exp_ev);
        repeat (2) @(negedge clk);
        chk($sformatf("%s_idle", nm), outv(), 0);
    endtask

    task automatic set_op(input int i, input int kind, input int len, input int code,
                          input int n, input int gap);
        sq_kind[i] = kind; sq_len[i] = len; sq_code[i] = code; sq_n[i] = n; sq_gap[i] = gap;
    endtask

    initial begin
        int w;
        int activity;
        total = 0;
        bad   = 0;

        //            kind  len      ok    code   n
        vecs[0]  = '{1'b0, 10'd200, 1'b1, 5'd2, 3'd2};
        vecs[1]  = '{1'b0, 10'd128, 1'b1, 5'd1, 3'd1};
        vecs[2]  = '{1'b0, 10'd129, 1'b1, 5'd2, 3'd2};
        vecs[3]  = '{1'b0, 10'd576, 1'b1, 5'd5, 3'd5};
        vecs[4]  = '{1'b1, 10'd384, 1'b1, 5'd8, 3'd3};
        vecs[5]  = '{1'b0, 10'd577, 1'b0, 5'd0, 3'd0};
        vecs[6]  = '{1'b1, 10'd385, 1'b0, 5'd0, 3'd0};
        vecs[7]  = '{1'b0, 10'd0,   1'b0, 5'd0, 3'd0};
        vecs[8]  = '{1'b1, 10'd0,   1'b0, 5'd0, 3'd0};
        vecs[9]  = '{1'b0, 10'd1,   1'b1, 5'd1, 3'd1};
        vecs[10] = '{1'b0, 10'd384, 1'b1, 5'd3, 3'd3};
        vecs[11] = '{1'b0, 10'd385, 1'b1, 5'd4, 3'd4};
        vecs[12] = '{1'b0, 10'd512, 1'b1, 5'd4, 3'd4};
        vecs[13] = '{1'b0, 10'd513, 1'b1, 5'd5, 3'd5};
        vecs[14] = '{1'b1, 10'd1,   1'b1, 5'd6, 3'd1};
        vecs[15] = '{1'b1, 10'd200, 1'b1, 5'd7, 3'd2};
        vecs[16] = '{1'b1, 10'd257, 1'b1, 5'd8, 3'd3};
        vecs[17] = '{1'b0, 10'd1023, 1'b0, 5'd0, 3'd0};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_kind  = 1'b0;
        bus.req_len   = 10'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outv(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", int'(bus.req_ready), 1);
        chk("reset_idle", outv(), 0);

        for (int i = 0; i < 18; i++) begin
            run_vec(i, vecs[i]);
        end

        // Three back-to-back into a two-deep FIFO.
        set_op(0, 0, 128, 1, 1, 0);
        set_op(1, 1, 200, 7, 2, 0);
        set_op(2, 0, 576, 5, 5, 0);
        run_seq("b2b", 3, 1'b1);

        // Valid requests behind invalid ones; pointers wrap several times.
        set_op(0, 1, 385, 0, 0, 0);
        set_op(1, 0, 129, 2, 2, 0);
        set_op(2, 0, 0,   0, 0, 0);
        set_op(3, 1, 1,   6, 1, 0);
        set_op(4, 0, 513, 5, 5, 0);
        set_op(5, 1, 256, 7, 2, 0);
        run_seq("mix", 6, 1'b0);

        // Second request arrives while the first is in its burst with the FIFO empty.
        set_op(0, 0, 200, 2, 2, 0);
        set_op(1, 1, 300, 8, 3, 4);
        run_seq("late", 2, 1'b0);

        // Reset during WAIT with one request still queued.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_kind = 1'b0; bus.req_len = 10'd576;
        @(posedge clk); #1;
        @(negedge clk);
        bus.req_kind = 1'b1; bus.req_len = 10'd200;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        w = 0;
        while (!bus.command[5] && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("rst_strobe_seen", int'(bus.command[5]), 1);
        repeat (2) @(negedge clk);
        chk("rst_pre_wait", int'(bus.command), 6'h05);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", outv(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        activity = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (outv() != 0 || !bus.req_ready) activity++;
        end
        chk("rst_quiet_after", activity, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
